// File: rtl/pixel_stream_arbiter.sv
// pixel_stream_arbiter: round-robin merge of NUM_SRC pixel streams into one
// registered sink stream tagged with the source index.
// Ports: _clock/_reset (sync, active-high), _start launches all sources,
// _ready/_valid/_out_0/_out_1/_out_src form the sink stream, _done flags the
// end of a run. Per-source side: src_start, src_ready, src_valid, src_done,
// src_out_0/src_out_1 (source i at [i*WIDTH +: WIDTH]).
// Optional: ARB_BEAT_CNT_EN adds _beats, a count of sink transfers per run.
module pixel_stream_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int WIDTH   = 32,
  parameter int SRC_W   = 2
) (
  input  logic                     _clock,
  input  logic                     _reset,
  input  logic                     _start,
  input  logic                     _ready,
  output logic                     _valid,
  output logic                     _done,
  output logic signed [WIDTH-1:0]  _out_0,
  output logic signed [WIDTH-1:0]  _out_1,
  output logic [SRC_W-1:0]         _out_src,
`ifdef ARB_BEAT_CNT_EN
  output logic [31:0]              _beats,
`endif
  output logic [NUM_SRC-1:0]       src_start,
  output logic [NUM_SRC-1:0]       src_ready,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC-1:0]       src_done,
  input  logic [NUM_SRC*WIDTH-1:0] src_out_0,
  input  logic [NUM_SRC*WIDTH-1:0] src_out_1
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [SRC_W-1:0]   rr;
  logic [SRC_W-1:0]   grant;
  logic [NUM_SRC-1:0] fin;
  logic               found;
  logic               load_en;
  logic               src_xfer;

  // The output register may take a new beat when empty or draining.
  assign load_en  = !_valid || _ready;
  assign src_xfer = (state == RUN) && found && load_en;

  assign src_start = {NUM_SRC{state == LAUNCH}};
  assign _done     = (state == DONE);
  assign src_ready = src_xfer ? (NUM_SRC'(1) << grant) : '0;

  // Round-robin scan starting just past the last served source;
  // finished sources are skipped even if they still show valid.
  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(rr) + k) % NUM_SRC;
      if (!found && src_valid[idx] && !fin[idx]) begin
        found = 1'b1;
        grant = SRC_W'(idx);
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (_start) state_nx = LAUNCH;
      LAUNCH:  state_nx = RUN;
      RUN:     if (&fin && !_valid) state_nx = DONE;
      DONE:    if (_start) state_nx = LAUNCH;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state    <= IDLE;
      rr       <= SRC_W'(NUM_SRC - 1);
      fin      <= '0;
      _valid   <= 1'b0;
      _out_0   <= '0;
      _out_1   <= '0;
      _out_src <= '0;
    end else begin
      state <= state_nx;
      // Done is ignored during LAUNCH so a stale flag from the
      // previous run cannot finish a source early.
      if (state == LAUNCH) begin
        fin <= '0;
      end else if (state == RUN) begin
        fin <= fin | (src_done & ~src_valid);
      end
      if (src_xfer) begin
        _valid   <= 1'b1;
        _out_0   <= src_out_0[int'(grant)*WIDTH +: WIDTH];
        _out_1   <= src_out_1[int'(grant)*WIDTH +: WIDTH];
        _out_src <= grant;
        rr       <= grant;
      end else if (load_en) begin
        _valid <= 1'b0;
      end
    end
  end

`ifdef ARB_BEAT_CNT_EN
  // Cleared on the edge that accepts _start so it reads 0 in LAUNCH.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      _beats <= '0;
    end else if (state_nx == LAUNCH) begin
      _beats <= '0;
    end else if (_valid && _ready) begin
      _beats <= _beats + 32'd1;
    end
  end
`endif

endmodule
